// File: rtl/display_ctrl.sv
// display_ctrl: round-robin CPU/switch display arbiter with hold time and debounced hex/binary select.
// Optional DISP_AUTO_CYCLE_EN adds a free-running auto-toggle of disp_select every AUTO_PERIOD cycles.
module display_ctrl #(
  parameter int HOLD_CYCLES = 8,
  parameter int DEB_CYCLES  = 16,
  parameter int AUTO_PERIOD = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        cpu_valid,
  input  logic [13:0] cpu_data,
  output logic        cpu_ready,
  input  logic        sw_valid,
  input  logic [13:0] sw_data,
  output logic        sw_ready,
  output logic [13:0] disp_value,
  output logic        disp_select,
  output logic        disp_src
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t      state, next_state;
  logic [15:0] hold_cnt;
  logic        rr_sw;
  logic        sync1, sync2, deb;
  logic [15:0] deb_cnt;
  logic        deb_hit, btn_rise, auto_hit;
  if (HOLD_CYCLES < 1 || DEB_CYCLES < 1 || AUTO_PERIOD < 1) begin : g_bad_param
    $error("display_ctrl: parameters must be at least 1");
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    if (state == IDLE) next_state = (cpu_ready || sw_ready) ? HOLD : IDLE;
    else next_state = (hold_cnt == 16'(HOLD_CYCLES - 1)) ? IDLE : HOLD;
  end
  // rr_sw set means the switch side wins the next tie
  always_comb begin
    cpu_ready = rst_n && state == IDLE && cpu_valid && (!sw_valid || !rr_sw);
    sw_ready  = rst_n && state == IDLE && sw_valid && (!cpu_valid || rr_sw);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold_cnt   <= '0;
      rr_sw      <= 1'b0;
      disp_value <= '0;
      disp_src   <= 1'b0;
    end else begin
      hold_cnt <= (state == HOLD) ? hold_cnt + 16'd1 : '0;
      if (cpu_ready) begin
        disp_value <= cpu_data;
        disp_src   <= 1'b0;
        rr_sw      <= 1'b1;
      end else if (sw_ready) begin
        disp_value <= sw_data;
        disp_src   <= 1'b1;
        rr_sw      <= 1'b0;
      end
    end
  assign deb_hit  = (sync2 != deb) && (deb_cnt == 16'(DEB_CYCLES - 1));
  assign btn_rise = deb_hit && sync2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb     <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1   <= btn_mode;
      sync2   <= sync1;
      deb     <= deb_hit ? sync2 : deb;
      deb_cnt <= (sync2 == deb || deb_hit) ? '0 : deb_cnt + 16'd1;
    end
`ifdef DISP_AUTO_CYCLE_EN
  logic [31:0] auto_cnt;
  assign auto_hit = auto_cnt == 32'(AUTO_PERIOD - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) auto_cnt <= '0;
    else auto_cnt <= (auto_hit || btn_rise) ? '0 : auto_cnt + 32'd1;
`else
  assign auto_hit = 1'b0;
`endif
  // a button edge and an auto expiry in the same cycle merge into one toggle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) disp_select <= 1'b1;
    else disp_select <= disp_select ^ (btn_rise || auto_hit);
endmodule

// File: doc/display_ctrl.md
DISPLAY_CTRL -- requirements
Module: display_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 8, minimum display-hold time in clock cycles after a value is accepted, legal range 1 to 2^16-1.
REQ-002 Parameter DEB_CYCLES, default 16, consecutive stable cycles needed to accept a new button level, legal range 1 to 2^16-1.
REQ-003 Parameter AUTO_PERIOD, default 1024, auto-toggle interval in cycles, used only under DISP_AUTO_CYCLE_EN.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 btn_mode  in  1  raw, asynchronous, bouncing mode button, active-high.
REQ-008 cpu_valid  in  1  CPU requester offers cpu_data.
REQ-009 cpu_data  in  14  CPU value to display.
REQ-010 cpu_ready  out  1  CPU transfer accepted this cycle.
REQ-011 sw_valid  in  1  switch requester offers sw_data.
REQ-012 sw_data  in  14  switch value to display.
REQ-013 sw_ready  out  1  switch transfer accepted this cycle.
REQ-014 disp_value  out  14  value driven to the display mux binary input.
REQ-015 disp_select  out  1  display mux select, 1 = hex, 0 = binary.
REQ-016 disp_src  out  1  source of disp_value, 0 = CPU, 1 = switch.

Function
REQ-017 The FSM SHALL have two states, IDLE and HOLD.
REQ-018 A transfer SHALL occur when a requester's valid and ready are both high at a rising clk edge.
REQ-019 cpu_ready and sw_ready SHALL be low outside IDLE, never both high, and high only for the granted requester whose valid is high.
REQ-020 In IDLE with exactly one valid high, that requester SHALL be granted.
REQ-021 In IDLE with both valids high, the requester not granted last SHALL win (round-robin), and the pointer SHALL update on every transfer.
REQ-022 On a transfer at edge N, disp_value and disp_src SHALL update at edge N and the FSM SHALL enter HOLD.
REQ-023 HOLD SHALL last exactly HOLD_CYCLES cycles, then return to IDLE, so the earliest next transfer is HOLD_CYCLES+1 cycles after the previous one.
REQ-024 A requester dropping valid before its transfer SHALL cause no state change, and disp_value SHALL be held between transfers.
REQ-025 btn_mode SHALL pass through a 2-flop synchronizer, then a debouncer whose level updates only after the synchronized level differs from it for DEB_CYCLES consecutive cycles, with any mismatch gap restarting the count.
REQ-026 Each debounced rising edge SHALL toggle disp_select exactly once, and falling edges SHALL have no effect.
REQ-027 disp_select toggling SHALL be independent of the FSM, and a toggle and a transfer SHALL be allowed in the same cycle.

Reset
REQ-028 While rst_n is low: FSM = IDLE, disp_value = 0, disp_src = 0, disp_select = 1, both readys = 0, round-robin pointer favours CPU, synchronizer, debouncer and all counters cleared.
REQ-029 Reset asserted mid-HOLD or mid-debounce SHALL abort the operation immediately with no pending toggle or transfer retained.

Configuration
REQ-030 With macro DISP_AUTO_CYCLE_EN defined, a free-running counter SHALL toggle disp_select every AUTO_PERIOD cycles.
REQ-031 With DISP_AUTO_CYCLE_EN defined, a debounced button edge SHALL toggle disp_select and restart the auto counter.
REQ-032 With DISP_AUTO_CYCLE_EN defined, a button toggle and an auto expiry in the same cycle SHALL yield a single toggle.
REQ-033 Without DISP_AUTO_CYCLE_EN, no auto counter SHALL exist and disp_select SHALL change only on debounced button edges.

Verification (HOLD_CYCLES=4, DEB_CYCLES=3, AUTO_PERIOD=20)
REQ-034 Directed scenario: cpu_valid=1 with cpu_data=14'h1ABC from IDLE -> cpu_ready=1 for 1 cycle, disp_value=14'h1ABC, disp_src=0, ready low for 4 cycles.
REQ-035 Directed scenario: both valids held high (cpu=14'h0001, sw=14'h0002) -> disp_value alternates 0001, 0002, 0001, with transfers every 5 cycles.
REQ-036 Directed scenario: btn_mode bounces 1,0,1 then stays high -> exactly one disp_select toggle (1 to 0), occurring 2+3 cycles after the last bounce.
REQ-037 Directed scenario: rst_n pulsed low during HOLD with disp_value=14'h3FFF -> outputs return to reset values and a new cpu_valid is accepted on the first cycle after release.
REQ-038 Directed scenario: DISP_AUTO_CYCLE_EN defined, no button activity -> disp_select toggles every 20 cycles, and a button edge coinciding with expiry gives one toggle with the counter restarted.
